// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone pipelined-mode bus bundle for wb_cmd_master.
// The master modport is the bus master's view; the slave modport is the view of
// whatever drives commands and models the Wishbone slave (e.g. a testbench).
interface wb_cmd_master_if #(
  parameter int AW = 8
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [31:0]   cmd_data_i;
  logic [3:0]    cmd_sel_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_data_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;

  logic          busy_o;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [31:0]   wb_data_o;
  logic [3:0]    wb_sel_o;
  logic          wb_stall_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic [31:0]   wb_data_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i,
    input  rsp_ready_i,
    input  wb_stall_i, wb_ack_i, wb_err_i, wb_data_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o,
    output busy_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i,
    output rsp_ready_i,
    output wb_stall_i, wb_ack_i, wb_err_i, wb_data_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o,
    input  busy_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone pipelined-mode master.
// Turns one valid/ready command into exactly one bus transaction and returns
// one valid/ready response. Bus address is a word address, passed unmodified.
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to abort a transaction that
// sees no ack/err within TIMEOUT_CYCLES cycles of entering REQ; without it a
// stuck slave hangs the master and rsp_timeout_o is tied low.
module wb_cmd_master #(
  parameter int AW             = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_cmd_master_if.master bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("wb_cmd_master: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    sel_q, sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          fin;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        expire;
`endif

  // Next-state and next-output decode; ack/err only count once the strobe is accepted
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    fin         = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
    expire        = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d    = bus.cmd_we_i;
          addr_d  = bus.cmd_addr_i;
          wdata_d = bus.cmd_data_i;
          sel_d   = bus.cmd_sel_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = ST_REQ;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      ST_REQ: begin
        // Ack/err while stalled is a slave protocol violation and is dropped
        if (!bus.wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
          fin     = bus.wb_ack_i || bus.wb_err_i;
        end
      end
      ST_WAIT: begin
        fin = bus.wb_ack_i || bus.wb_err_i;
      end
      ST_RSP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // A completion in the expiry cycle wins over the abort
    if (state_q == ST_REQ || state_q == ST_WAIT) begin
      cnt_d  = cnt_q + 16'd1;
      expire = (cnt_q == TO_LAST) && !fin;
    end
`endif

    // Normal completion; err wins over ack when both are high
    if (fin) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = bus.wb_err_i;
      rsp_data_d  = (bus.wb_err_i || we_q) ? 32'd0 : bus.wb_data_i;
      state_d     = ST_RSP;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_timeout_d = 1'b0;
`endif
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    if (expire) begin
      cyc_d         = 1'b0;
      stb_d         = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_data_d    = 32'd0;
      state_d       = ST_RSP;
    end
`endif
  end

  // State and output registers; reset aborts any transaction immediately
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      sel_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      cnt_q         <= 16'd0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign bus.cmd_ready_o = (state_q == ST_IDLE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = stb_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_data_o   = wdata_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
  assign bus.rsp_timeout_o = rsp_timeout_q;
`else
  assign bus.rsp_timeout_o = 1'b0;
`endif

endmodule
